// File: rtl/qdr_b4_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : qdr_b4_pkg
//  Description : Shared types and default widths for the burst-of-4 QDR-II+
//                command sequencer: command encoding, default address/data/
//                byte-write widths and the burst length.
//  Revision    : 1.0  initial release
// ============================================================================
package qdr_b4_pkg;

    // Command placed on the shared address bus in a given K cycle.
    typedef enum logic [1:0] {
        CMD_NOP = 2'd0,
        CMD_RD  = 2'd1,
        CMD_WR  = 2'd2
    } cmd_t;

    localparam int ADDR_W    = 22;  // SRAM address width (SA)
    localparam int DQ_W      = 18;  // data bits per beat
    localparam int BW_W      = 2;   // byte-write lanes per beat, 9 bits each
    localparam int BURST_LEN = 4;   // beats per burst

endpackage : qdr_b4_pkg
`default_nettype wire

// File: rtl/qdr_rd_expect_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : qdr_rd_expect_pipe
//  Description : RD_LAT-deep {valid,tag} shift register. A read issued on the
//                bus in cycle c is presented on o_valid/o_tag in cycle
//                c+RD_LAT. Asynchronous active-high reset clears every stage.
//  Revision    : 1.0  initial release
//
//  Ports
//    clk          K-domain clock
//    rst          asynchronous reset, active high
//    i_valid      a read command is on the bus this cycle
//    i_tag        tag of that read
//    o_valid      one-cycle expect strobe
//    o_tag        tag of the expected read (0 when o_valid is low)
//    o_any_valid  at least one read is still travelling through the pipe
// ============================================================================
module qdr_rd_expect_pipe #(
    parameter int RD_LAT = 8,
    parameter int TAG_W  = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_valid,
    input  logic [TAG_W-1:0] i_tag,
    output logic             o_valid,
    output logic [TAG_W-1:0] o_tag,
    output logic             o_any_valid
);

    logic [RD_LAT-1:0]            r_vld;
    logic [RD_LAT-1:0][TAG_W-1:0] r_tag;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_vld <= '0;
            r_tag <= '0;
        end else begin
            r_vld[0] <= i_valid;
            r_tag[0] <= i_tag;
            for (int i = 1; i < RD_LAT; i++) begin
                r_vld[i] <= r_vld[i-1];
                r_tag[i] <= r_tag[i-1];
            end
        end
    end

    assign o_valid     = r_vld[RD_LAT-1];
    // Tags shift unconditionally, so mask the stale value outside a strobe.
    assign o_tag       = r_vld[RD_LAT-1] ? r_tag[RD_LAT-1] : '0;
    assign o_any_valid = |r_vld;

endmodule : qdr_rd_expect_pipe
`default_nettype wire

// File: rtl/qdr_b4_cmd_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : qdr_b4_cmd_sequencer
//  Description : Upstream command/data driver for an 18-bit burst-of-4
//                QDR-II+ SRAM. Arbitrates independent read and write
//                requests onto the shared address bus (at most one command
//                per K cycle), splits each 4-beat write burst into rise/fall
//                halves for the ODDR stage and emits a read-expect strobe/tag
//                RD_LAT cycles after each read command.
//  Revision    : 1.0  initial release
//
//  Build option
//    QDR_BW_MASK_EN  defined: wr_req_bw_n is carried per beat to
//                    qdr_bw_n_rise/fall. Undefined: the mask is ignored and
//                    all bytes are written in data cycles.
//
//  Ports
//    clk, rst                    K clock, asynchronous active-high reset
//    wr_req_valid/ready/addr/    write request channel; data beat0 in the
//      data/bw_n                 low DQ_W bits, bw_n active-low per beat
//    rd_req_valid/ready/addr/tag read request channel
//    qdr_sa, qdr_r_n, qdr_w_n    SRAM address and active-low strobes
//    qdr_d_rise/fall             even/odd beat data
//    qdr_bw_n_rise/fall          even/odd beat byte-write enables
//    rd_exp_valid, rd_exp_tag    read-expect strobe and tag
//    busy                        write beats pending or reads in flight
// ============================================================================
module qdr_b4_cmd_sequencer #(
    parameter int ADDR_W = qdr_b4_pkg::ADDR_W,
    parameter int DQ_W   = qdr_b4_pkg::DQ_W,
    parameter int BW_W   = qdr_b4_pkg::BW_W,
    parameter int TAG_W  = 4,
    parameter int WR_DLY = 1,   // must be >= 1
    parameter int RD_LAT = 8    // must be >= 1
) (
    input  logic                                    clk,
    input  logic                                    rst,
    input  logic                                    wr_req_valid,
    output logic                                    wr_req_ready,
    input  logic [ADDR_W-1:0]                       wr_req_addr,
    input  logic [qdr_b4_pkg::BURST_LEN*DQ_W-1:0]   wr_req_data,
    input  logic [qdr_b4_pkg::BURST_LEN*BW_W-1:0]   wr_req_bw_n,
    input  logic                                    rd_req_valid,
    output logic                                    rd_req_ready,
    input  logic [ADDR_W-1:0]                       rd_req_addr,
    input  logic [TAG_W-1:0]                        rd_req_tag,
    output logic [ADDR_W-1:0]                       qdr_sa,
    output logic                                    qdr_r_n,
    output logic                                    qdr_w_n,
    output logic [DQ_W-1:0]                         qdr_d_rise,
    output logic [DQ_W-1:0]                         qdr_d_fall,
    output logic [BW_W-1:0]                         qdr_bw_n_rise,
    output logic [BW_W-1:0]                         qdr_bw_n_fall,
    output logic                                    rd_exp_valid,
    output logic [TAG_W-1:0]                        rd_exp_tag,
    output logic                                    busy
);

    import qdr_b4_pkg::*;

    localparam int c_burst_dw = BURST_LEN * DQ_W;
    localparam int c_last_stg = WR_DLY - 1;

    // ------------------------------------------------------------------
    // Bus command registers
    // ------------------------------------------------------------------
    logic [ADDR_W-1:0] r_qdr_sa;
    logic              r_qdr_r_n;
    logic              r_qdr_w_n;
    logic [TAG_W-1:0]  r_rd_tag;
    logic              r_prio_wr;   // 1: write wins the next conflict

    logic              w_rd_elig;
    logic              w_wr_elig;
    logic              w_rd_ready;
    logic              w_wr_ready;
    cmd_t              w_cmd;

    // A port is eligible unless its own command is on the bus right now,
    // i.e. was accepted last cycle. The ready of one port looks only at the
    // other port's valid, never its own.
    always_comb begin
        w_rd_elig  = ~rst & r_qdr_r_n;
        w_wr_elig  = ~rst & r_qdr_w_n;
        w_rd_ready = w_rd_elig & ~(w_wr_elig & wr_req_valid &  r_prio_wr);
        w_wr_ready = w_wr_elig & ~(w_rd_elig & rd_req_valid & ~r_prio_wr);
        w_cmd      = CMD_NOP;
        if (rd_req_valid && w_rd_ready) begin
            w_cmd = CMD_RD;
        end else if (wr_req_valid && w_wr_ready) begin
            w_cmd = CMD_WR;
        end
    end

    assign rd_req_ready = w_rd_ready;
    assign wr_req_ready = w_wr_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_qdr_sa  <= '0;
            r_qdr_r_n <= 1'b1;
            r_qdr_w_n <= 1'b1;
            r_rd_tag  <= '0;
            r_prio_wr <= 1'b0;
        end else begin
            r_qdr_r_n <= (w_cmd != CMD_RD);
            r_qdr_w_n <= (w_cmd != CMD_WR);
            case (w_cmd)
                CMD_RD: begin
                    r_qdr_sa  <= rd_req_addr;
                    r_rd_tag  <= rd_req_tag;
                    r_prio_wr <= 1'b1;
                end
                CMD_WR: begin
                    r_qdr_sa  <= wr_req_addr;
                    r_prio_wr <= 1'b0;
                end
                default: ;  // idle: address bus holds its last value
            endcase
        end
    end

    assign qdr_sa  = r_qdr_sa;
    assign qdr_r_n = r_qdr_r_n;
    assign qdr_w_n = r_qdr_w_n;

    // ------------------------------------------------------------------
    // Write beat staging. Stage 0 is valid in the write command cycle;
    // stage WR_DLY-1 loads the first data cycle's output registers.
    // ------------------------------------------------------------------
    logic [WR_DLY-1:0]                 r_ws_vld;
    logic [WR_DLY-1:0][c_burst_dw-1:0] r_ws_data;
    logic [2*DQ_W-1:0]                 r_hi_data;   // beats 2/3
    logic                              r_second;    // next cycle emits beats 2/3
`ifdef QDR_BW_MASK_EN
    logic [WR_DLY-1:0][BURST_LEN*BW_W-1:0] r_ws_bw;
    logic [2*BW_W-1:0]                     r_hi_bw;
`else
    logic w_unused_bw;
    assign w_unused_bw = ^wr_req_bw_n;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ws_vld  <= '0;
            r_ws_data <= '0;
`ifdef QDR_BW_MASK_EN
            r_ws_bw   <= '0;
`endif
        end else begin
            r_ws_vld[0] <= (w_cmd == CMD_WR);
            if (w_cmd == CMD_WR) begin
                r_ws_data[0] <= wr_req_data;
`ifdef QDR_BW_MASK_EN
                r_ws_bw[0]   <= wr_req_bw_n;
`endif
            end
            for (int i = 1; i < WR_DLY; i++) begin
                r_ws_vld[i]  <= r_ws_vld[i-1];
                r_ws_data[i] <= r_ws_data[i-1];
`ifdef QDR_BW_MASK_EN
                r_ws_bw[i]   <= r_ws_bw[i-1];
`endif
            end
        end
    end

    // Writes are at least two cycles apart, so a new first-data cycle can
    // never collide with a pending second-data cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            qdr_d_rise    <= '0;
            qdr_d_fall    <= '0;
            qdr_bw_n_rise <= '0;
            qdr_bw_n_fall <= '0;
            r_hi_data     <= '0;
            r_second      <= 1'b0;
`ifdef QDR_BW_MASK_EN
            r_hi_bw       <= '0;
`endif
        end else if (r_ws_vld[c_last_stg]) begin
            qdr_d_rise <= r_ws_data[c_last_stg][0      +: DQ_W];
            qdr_d_fall <= r_ws_data[c_last_stg][DQ_W   +: DQ_W];
            r_hi_data  <= r_ws_data[c_last_stg][2*DQ_W +: 2*DQ_W];
            r_second   <= 1'b1;
`ifdef QDR_BW_MASK_EN
            qdr_bw_n_rise <= r_ws_bw[c_last_stg][0      +: BW_W];
            qdr_bw_n_fall <= r_ws_bw[c_last_stg][BW_W   +: BW_W];
            r_hi_bw       <= r_ws_bw[c_last_stg][2*BW_W +: 2*BW_W];
`else
            qdr_bw_n_rise <= '0;
            qdr_bw_n_fall <= '0;
`endif
        end else if (r_second) begin
            qdr_d_rise <= r_hi_data[0    +: DQ_W];
            qdr_d_fall <= r_hi_data[DQ_W +: DQ_W];
            r_second   <= 1'b0;
`ifdef QDR_BW_MASK_EN
            qdr_bw_n_rise <= r_hi_bw[0    +: BW_W];
            qdr_bw_n_fall <= r_hi_bw[BW_W +: BW_W];
`else
            qdr_bw_n_rise <= '0;
            qdr_bw_n_fall <= '0;
`endif
        end else begin
            qdr_d_rise    <= '0;
            qdr_d_fall    <= '0;
            qdr_bw_n_rise <= '1;
            qdr_bw_n_fall <= '1;
            r_second      <= 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Read expect: fed from the registered strobe, so the delay counts
    // from the cycle the read is actually on the bus.
    // ------------------------------------------------------------------
    logic w_exp_any;

    qdr_rd_expect_pipe #(
        .RD_LAT (RD_LAT),
        .TAG_W  (TAG_W)
    ) u_rd_expect_pipe (
        .clk         (clk),
        .rst         (rst),
        .i_valid     (~r_qdr_r_n),
        .i_tag       (r_rd_tag),
        .o_valid     (rd_exp_valid),
        .o_tag       (rd_exp_tag),
        .o_any_valid (w_exp_any)
    );

    assign busy = (|r_ws_vld) | r_second | ~r_qdr_r_n | w_exp_any;

endmodule : qdr_b4_cmd_sequencer
`default_nettype wire

// File: tb/tb_qdr_b4_cmd_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_qdr_b4_cmd_sequencer
//  Description : Scoreboard bench for qdr_b4_cmd_sequencer. The driver pushes
//                expected bus commands, data cycles and read expects when a
//                request is accepted; a negedge monitor pops and compares.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_qdr_b4_cmd_sequencer;

    localparam int ADDR_W = 22;
    localparam int DQ_W   = 18;
    localparam int BW_W   = 2;
    localparam int TAG_W  = 4;
    localparam int WR_DLY = 1;
    localparam int RD_LAT = 8;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic                wr_req_valid = 1'b0;
    logic                wr_req_ready;
    logic [ADDR_W-1:0]   wr_req_addr = '0;
    logic [4*DQ_W-1:0]   wr_req_data = '0;
    logic [4*BW_W-1:0]   wr_req_bw_n = '0;
    logic                rd_req_valid = 1'b0;
    logic                rd_req_ready;
    logic [ADDR_W-1:0]   rd_req_addr = '0;
    logic [TAG_W-1:0]    rd_req_tag = '0;
    logic [ADDR_W-1:0]   qdr_sa;
    logic                qdr_r_n, qdr_w_n;
    logic [DQ_W-1:0]     qdr_d_rise, qdr_d_fall;
    logic [BW_W-1:0]     qdr_bw_n_rise, qdr_bw_n_fall;
    logic                rd_exp_valid;
    logic [TAG_W-1:0]    rd_exp_tag;
    logic                busy;

    always #5 clk = ~clk;

    qdr_b4_cmd_sequencer #(
        .ADDR_W(ADDR_W), .DQ_W(DQ_W), .BW_W(BW_W), .TAG_W(TAG_W),
        .WR_DLY(WR_DLY), .RD_LAT(RD_LAT)
    ) dut (
        .clk(clk), .rst(rst),
        .wr_req_valid(wr_req_valid), .wr_req_ready(wr_req_ready),
        .wr_req_addr(wr_req_addr), .wr_req_data(wr_req_data), .wr_req_bw_n(wr_req_bw_n),
        .rd_req_valid(rd_req_valid), .rd_req_ready(rd_req_ready),
        .rd_req_addr(rd_req_addr), .rd_req_tag(rd_req_tag),
        .qdr_sa(qdr_sa), .qdr_r_n(qdr_r_n), .qdr_w_n(qdr_w_n),
        .qdr_d_rise(qdr_d_rise), .qdr_d_fall(qdr_d_fall),
        .qdr_bw_n_rise(qdr_bw_n_rise), .qdr_bw_n_fall(qdr_bw_n_fall),
        .rd_exp_valid(rd_exp_valid), .rd_exp_tag(rd_exp_tag), .busy(busy)
    );

    typedef struct { logic [ADDR_W-1:0] addr; logic [TAG_W-1:0] tag; } rd_stim_t;
    typedef struct { logic [ADDR_W-1:0] addr; logic [4*DQ_W-1:0] data; logic [4*BW_W-1:0] bw; } wr_stim_t;
    typedef struct { int cyc; bit is_rd; logic [ADDR_W-1:0] addr; } cmd_exp_t;
    typedef struct { int cyc; logic [DQ_W-1:0] rise; logic [DQ_W-1:0] fall;
                     logic [BW_W-1:0] bwr; logic [BW_W-1:0] bwf; } dat_exp_t;
    typedef struct { int cyc; logic [TAG_W-1:0] tag; } rdx_exp_t;

    rd_stim_t rd_stim[$];
    wr_stim_t wr_stim[$];
    cmd_exp_t cmd_q[$];
    dat_exp_t dat_q[$];
    rdx_exp_t rdx_q[$];
    int       rd_acc[$];
    int       wr_acc[$];
    string    seq = "";

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int rel_cyc = 0;
    bit rd_en = 1'b0, wr_en = 1'b0;
    bit rd_hs = 1'b0, wr_hs = 1'b0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Byte-write enables the DUT should present for one beat.
    function automatic logic [BW_W-1:0] bw_model(input logic [BW_W-1:0] b);
`ifdef QDR_BW_MASK_EN
        return b;
`else
        return '0;
`endif
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // ------------------------------------------------------------------
    // Monitor
    // ------------------------------------------------------------------
    always @(negedge clk) begin
        cmd_exp_t c;
        dat_exp_t d;
        rdx_exp_t x;
        if (rst) begin
            rd_hs = 1'b0;
            wr_hs = 1'b0;
        end else begin
            if (rd_hs) chk("rd_ready_after_accept", rd_req_ready, 0);
            if (wr_hs) chk("wr_ready_after_accept", wr_req_ready, 0);
            chk("never_both_strobes", qdr_r_n | qdr_w_n, 1);

            if (!qdr_r_n || !qdr_w_n) begin
                if (cmd_q.size() == 0) begin
                    chk("unexpected_cmd", {qdr_r_n, qdr_w_n}, 2'b11);
                end else begin
                    c = cmd_q.pop_front();
                    chk("cmd_cycle", cyc, c.cyc);
                    chk("cmd_type", {qdr_r_n, qdr_w_n}, c.is_rd ? 2'b01 : 2'b10);
                    chk("cmd_addr", qdr_sa, c.addr);
                end
            end
            if (cmd_q.size() > 0 && cmd_q[0].cyc < cyc) begin
                c = cmd_q.pop_front();
                chk("cmd_missing_at_cycle", cyc, c.cyc);
            end

            if (dat_q.size() > 0 && dat_q[0].cyc == cyc) begin
                d = dat_q.pop_front();
                chk("d_rise", qdr_d_rise, d.rise);
                chk("d_fall", qdr_d_fall, d.fall);
                chk("bw_n_rise", qdr_bw_n_rise, d.bwr);
                chk("bw_n_fall", qdr_bw_n_fall, d.bwf);
            end else begin
                chk("idle_d", {qdr_d_rise, qdr_d_fall}, '0);
                if (cyc > rel_cyc) chk("idle_bw_n", {qdr_bw_n_rise, qdr_bw_n_fall}, 4'hF);
            end

            if (rd_exp_valid) begin
                if (rdx_q.size() == 0) begin
                    chk("unexpected_rd_exp", rd_exp_valid, 0);
                end else begin
                    x = rdx_q.pop_front();
                    chk("rd_exp_cycle", cyc, x.cyc);
                    chk("rd_exp_tag", rd_exp_tag, x.tag);
                end
            end
            if (rdx_q.size() > 0 && rdx_q[0].cyc < cyc) begin
                x = rdx_q.pop_front();
                chk("rd_exp_missing_at_cycle", cyc, x.cyc);
            end

            rd_hs = rd_req_valid & rd_req_ready;
            wr_hs = wr_req_valid & wr_req_ready;
        end
    end

    // ------------------------------------------------------------------
    // Driver
    // ------------------------------------------------------------------
    task automatic drive();
        rd_req_valid = rd_en && (rd_stim.size() > 0);
        rd_req_addr  = rd_req_valid ? rd_stim[0].addr : '0;
        rd_req_tag   = rd_req_valid ? rd_stim[0].tag  : '0;
        wr_req_valid = wr_en && (wr_stim.size() > 0);
        wr_req_addr  = wr_req_valid ? wr_stim[0].addr : '0;
        wr_req_data  = wr_req_valid ? wr_stim[0].data : '0;
        wr_req_bw_n  = wr_req_valid ? wr_stim[0].bw   : '0;
    endtask

    task automatic step();
        rd_stim_t rs;
        wr_stim_t ws;
        cmd_exp_t c;
        dat_exp_t d;
        rdx_exp_t x;
        @(posedge clk);
        #1;
        // Accepted last cycle -> command on the bus in the current cycle.
        if (rd_hs) begin
            rs = rd_stim.pop_front();
            c.cyc = cyc; c.is_rd = 1'b1; c.addr = rs.addr;
            cmd_q.push_back(c);
            x.cyc = cyc + RD_LAT; x.tag = rs.tag;
            rdx_q.push_back(x);
            rd_acc.push_back(cyc - 1);
            seq = {seq, "R"};
        end
        if (wr_hs) begin
            ws = wr_stim.pop_front();
            c.cyc = cyc; c.is_rd = 1'b0; c.addr = ws.addr;
            cmd_q.push_back(c);
            d.cyc  = cyc + WR_DLY;
            d.rise = ws.data[0 +: DQ_W];      d.fall = ws.data[DQ_W +: DQ_W];
            d.bwr  = bw_model(ws.bw[0 +: BW_W]); d.bwf = bw_model(ws.bw[BW_W +: BW_W]);
            dat_q.push_back(d);
            d.cyc  = cyc + WR_DLY + 1;
            d.rise = ws.data[2*DQ_W +: DQ_W]; d.fall = ws.data[3*DQ_W +: DQ_W];
            d.bwr  = bw_model(ws.bw[2*BW_W +: BW_W]); d.bwf = bw_model(ws.bw[3*BW_W +: BW_W]);
            dat_q.push_back(d);
            wr_acc.push_back(cyc - 1);
            seq = {seq, "W"};
        end
        drive();
    endtask

    function automatic int pending();
        return rd_stim.size() + wr_stim.size() + cmd_q.size() + dat_q.size() + rdx_q.size();
    endfunction

    task automatic drain(input string name, input int max);
        int n = 0;
        while (pending() != 0 && n < max) begin
            step();
            n++;
        end
        chk({name, "_drain_pending"}, pending(), 0);
    endtask

    function automatic wr_stim_t mk_wr(input logic [ADDR_W-1:0] a, input logic [DQ_W-1:0] b0,
                                       input logic [DQ_W-1:0] b1, input logic [DQ_W-1:0] b2,
                                       input logic [DQ_W-1:0] b3, input logic [4*BW_W-1:0] bw);
        wr_stim_t s;
        s.addr = a; s.data = {b3, b2, b1, b0}; s.bw = bw;
        return s;
    endfunction

    function automatic rd_stim_t mk_rd(input logic [ADDR_W-1:0] a, input logic [TAG_W-1:0] t);
        rd_stim_t s;
        s.addr = a; s.tag = t;
        return s;
    endfunction

    initial begin
        int n;
        int target;

        // ---------------- reset state ----------------
        repeat (3) step();
        chk("rst_r_n", qdr_r_n, 1);
        chk("rst_w_n", qdr_w_n, 1);
        chk("rst_sa", qdr_sa, 0);
        chk("rst_d", {qdr_d_rise, qdr_d_fall}, 0);
        chk("rst_bw_n", {qdr_bw_n_rise, qdr_bw_n_fall}, 4'h0);
        chk("rst_exp", {rd_exp_valid, rd_exp_tag}, 0);
        chk("rst_busy", busy, 0);
        chk("rst_readies", {rd_req_ready, wr_req_ready}, 2'b00);
        rst = 1'b0;
        rel_cyc = cyc;

        // ---------------- single writes ----------------
        // Mask 10_01_00_11: beat0=11 beat1=00 beat2=01 beat3=10.
        wr_stim.push_back(mk_wr(22'h01234, 18'h00001, 18'h00002, 18'h00003, 18'h00004, 8'b10_01_00_11));
        wr_stim.push_back(mk_wr(22'h3ABCD, 18'h3FFFF, 18'h15555, 18'h2AAAA, 18'h00100, 8'b00_11_10_01));
        wr_en = 1'b1;
        drive();
        drain("single_write", 40);
        chk("busy_after_writes", busy, 0);

        // ---------------- held reads ----------------
        rd_acc.delete();
        rd_stim.push_back(mk_rd(22'h10, 4'h5));
        rd_stim.push_back(mk_rd(22'h20, 4'h6));
        rd_en = 1'b1;
        drive();
        drain("held_reads", 40);
        if (rd_acc.size() == 2) chk("read_accept_spacing", rd_acc[1] - rd_acc[0], 2);
        else chk("read_accept_count", rd_acc.size(), 2);
        chk("busy_after_reads", busy, 0);

        // ---------------- both ports from reset release ----------------
        rst = 1'b1;
        step(); step();
        rd_acc.delete(); wr_acc.delete(); seq = "";
        rd_stim.push_back(mk_rd(22'h00100, 4'h1));
        rd_stim.push_back(mk_rd(22'h00200, 4'h2));
        rd_stim.push_back(mk_rd(22'h00300, 4'h3));
        wr_stim.push_back(mk_wr(22'h10001, 18'h11, 18'h12, 18'h13, 18'h14, 8'h00));
        wr_stim.push_back(mk_wr(22'h10002, 18'h21, 18'h22, 18'h23, 18'h24, 8'h00));
        wr_stim.push_back(mk_wr(22'h10003, 18'h31, 18'h32, 18'h33, 18'h34, 8'h00));
        rst = 1'b0;
        rel_cyc = cyc;
        drive();
        drain("arbitration", 60);
        chk("arb_sequence_rwrwrw", seq == "RWRWRW", 1);
        if (rd_acc.size() == 3 && wr_acc.size() == 3) begin
            chk("arb_first_read_at_release", rd_acc[0] - rel_cyc, 0);
            chk("arb_full_bus_span", wr_acc[2] - rd_acc[0], 5);
        end else begin
            chk("arb_accept_count", rd_acc.size() + wr_acc.size(), 6);
        end

        // ---------------- reset during beat-2/3 cycle ----------------
        rd_acc.delete(); wr_acc.delete();
        rd_stim.push_back(mk_rd(22'h00155, 4'h5));
        wr_stim.push_back(mk_wr(22'h002AA, 18'h0000A, 18'h0000B, 18'h0000C, 18'h0000D, 8'h00));
        drive();
        n = 0;
        while (wr_acc.size() == 0 && n < 10) begin step(); n++; end
        chk("rst_test_write_accepted", wr_acc.size(), 1);
        target = (wr_acc.size() > 0) ? wr_acc[0] + 2 + WR_DLY : cyc;
        n = 0;
        while (cyc < target && n < 10) begin step(); n++; end
        chk("pre_rst_d_rise_beat2", qdr_d_rise, 18'h0000C);
        chk("pre_rst_busy", busy, 1);
        #1 rst = 1'b1;
        #1;
        chk("async_rst_w_n", qdr_w_n, 1);
        chk("async_rst_d", {qdr_d_rise, qdr_d_fall}, 0);
        chk("async_rst_exp", rd_exp_valid, 0);
        chk("async_rst_busy", busy, 0);
        chk("async_rst_readies", {rd_req_ready, wr_req_ready}, 2'b00);
        cmd_q.delete(); dat_q.delete(); rdx_q.delete();
        rd_stim.delete(); wr_stim.delete();
        rd_en = 1'b0; wr_en = 1'b0;
        step(); step();
        rst = 1'b0;
        rel_cyc = cyc;
        drive();
        repeat (RD_LAT + 6) step();
        chk("post_rst_busy", busy, 0);
        chk("post_rst_pending", pending(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, vectors=%0d", vectors);
        $fatal(1, "watchdog");
    end

endmodule : tb_qdr_b4_cmd_sequencer
`default_nettype wire
